picorv32_mem_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one picorv32 native memory port (valid/ready, addr, wdata, wstrb, rdata, instr) between master 0 and master 1. Typical use: two picorv32 cores, or a core plus a DMA/debug master, in front of the single behavioural or on-chip memory. Includes a response watchdog so a silent slave cannot hang a core.

---
 rtl/picorv32_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_picorv32_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// picorv32_mem_arbiter
//
// Round-robin arbiter that lets two picorv32 native-memory masters share one
// slave port. A grant is held for exactly one transfer. Every transfer is
// followed by one idle cycle, so s_valid always drops the cycle after
// s_ready. A response watchdog aborts a transfer whose slave never answers.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   m0_* / m1_*              master request (valid/instr/addr/wdata/wstrb)
//                            and completion (ready/rdata)
//   s_*                      shared slave port
//   err                      one-cycle pulse when the watchdog aborts
//   gnt                      one-hot current owner, 00 when idle
//
// Parameters
//   TIMEOUT                  BUSY cycles allowed without s_ready, 0 = off
//   ERR_DATA                 rdata returned to the master on an abort
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; picks the next master, preferring not last_grant
// BUSY0 | master 0 owns the slave port, waiting for s_ready
// BUSY1 | master 1 owns the slave port, waiting for s_ready
// ABORT | watchdog expired; owner gets ready + ERR_DATA for one cycle
// ---------------------------------------------------------------------------
module picorv32_mem_arbiter #(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        err,
    output logic [1:0]  gnt
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);
    localparam bit            WDOG_EN = (TIMEOUT > 0);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY0 = 2'd1;
    localparam logic [1:0] BUSY1 = 2'd2;
    localparam logic [1:0] ABORT = 2'd3;

    logic [1:0]    state, state_nxt;
    logic          owner, owner_nxt;
    logic          last_grant, last_grant_nxt;
    logic [CW-1:0] wdog, wdog_nxt;
    logic [CW-1:0] wdog_inc;
    logic          busy;
    logic          abort0, abort1;

    assign wdog_inc = wdog + CW'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wdog       <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            wdog       <= wdog_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        wdog_nxt       = wdog;
        case (state)
            IDLE: begin
                wdog_nxt = '0;
                // m0 wins unless m1 is also asking and m0 had the last turn
                if (m0_valid && (!m1_valid || last_grant)) begin
                    state_nxt = BUSY0;
                    owner_nxt = 1'b0;
                end else if (m1_valid) begin
                    state_nxt = BUSY1;
                    owner_nxt = 1'b1;
                end
            end
            BUSY0, BUSY1: begin
                // a response on the expiry edge still completes normally
                if (s_ready) begin
                    last_grant_nxt = owner;
                    state_nxt      = IDLE;
                end else if (WDOG_EN) begin
                    if (wdog_inc == TO_VAL) begin
                        state_nxt = ABORT;
                    end else begin
                        wdog_nxt = wdog_inc;
                    end
                end
            end
            ABORT: begin
                last_grant_nxt = owner;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy   = (state == BUSY0) || (state == BUSY1);
    assign abort0 = (state == ABORT) && !owner;
    assign abort1 = (state == ABORT) && owner;

    assign s_valid = busy;
    assign s_instr = busy ? (owner ? m1_instr : m0_instr) : 1'b0;
    assign s_addr  = busy ? (owner ? m1_addr  : m0_addr)  : 32'h0;
    assign s_wdata = busy ? (owner ? m1_wdata : m0_wdata) : 32'h0;
    assign s_wstrb = busy ? (owner ? m1_wstrb : m0_wstrb) : 4'h0;

    // s_ready is only ever routed to the owner while BUSY
    assign m0_ready = ((state == BUSY0) && s_ready) || abort0;
    assign m1_ready = ((state == BUSY1) && s_ready) || abort1;
    assign m0_rdata = (state == BUSY0) ? s_rdata : (abort0 ? ERR_DATA : 32'h0);
    assign m1_rdata = (state == BUSY1) ? s_rdata : (abort1 ? ERR_DATA : 32'h0);

    assign err = (state == ABORT);
    assign gnt = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
module tb_picorv32_mem_arbiter;

    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        err;
    logic [1:0]  gnt;

    always #5 clk = ~clk;

    picorv32_mem_arbiter #(.TIMEOUT(4), .ERR_DATA(ERR)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .err(err), .gnt(gnt)
    );

    typedef struct {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        req_t        r;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        bit          v0, v1, i0, i1;
        logic [31:0] a0, a1, d0, d1;
        logic [3:0]  w0, w1;
        int          dly;
        bit          first;
    } vec_t;

    req_t        req_q0[$], req_q1[$];
    exp_t        exp_q0[$], exp_q1[$];
    bit          order_q[$];
    bit          order_en;
    logic [31:0] wlog[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          slave_mode = 0;   // 0 normal, 1 never ready, 2 stray ready
    int          slave_dly  = 0;
    logic        ack0, ack1;
    bit          prev_fire;
    int          run;

    function automatic logic [31:0] sdata(input logic [31:0] a);
        return (a == 32'h10) ? 32'h1234_5678 : (a ^ 32'hC0DE_0000);
    endfunction

    function automatic req_t mk(input logic i, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] w);
        req_t r;
        r.instr = i; r.addr = a; r.wdata = d; r.wstrb = w;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // slave: answers after slave_dly valid cycles, logs stores to 0x3FC
    initial begin
        int cnt;
        cnt = 0;
        s_ready = 1'b0;
        s_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (slave_mode == 2) begin
                s_ready = 1'b1;
                s_rdata = 32'hBAD0_BAD0;
            end else if (s_ready) begin
                s_ready = 1'b0;
                cnt = 0;
            end else if (s_valid && slave_mode == 0) begin
                if (cnt >= slave_dly) begin
                    s_ready = 1'b1;
                    s_rdata = sdata(s_addr);
                    if (s_wstrb != 4'h0 && s_addr == 32'h3FC) wlog.push_back(s_wdata);
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    function automatic exp_t mk_exp(input req_t r);
        exp_t e;
        e.r = r;
        e.err = (slave_mode == 1);
        e.rdata = e.err ? ERR : sdata(r.addr);
        return e;
    endfunction

    task automatic drive_masters();
        req_t r;
        if (m0_valid && ack0) m0_valid = 1'b0;
        if (m1_valid && ack1) m1_valid = 1'b0;
        ack0 = 1'b0;
        ack1 = 1'b0;
        if (!m0_valid && req_q0.size() > 0) begin
            r = req_q0.pop_front();
            m0_instr = r.instr; m0_addr = r.addr; m0_wdata = r.wdata; m0_wstrb = r.wstrb;
            m0_valid = 1'b1;
            exp_q0.push_back(mk_exp(r));
        end
        if (!m1_valid && req_q1.size() > 0) begin
            r = req_q1.pop_front();
            m1_instr = r.instr; m1_addr = r.addr; m1_wdata = r.wdata; m1_wstrb = r.wstrb;
            m1_valid = 1'b1;
            exp_q1.push_back(mk_exp(r));
        end
    endtask

    task automatic check_xfer(input bit m, input exp_t e);
        chk(m ? "m1_rdata" : "m0_rdata", m ? m1_rdata : m0_rdata, e.rdata);
        chk("err_flag", 32'(err), 32'(e.err));
        chk("gnt_owner", 32'(gnt), m ? 32'd2 : 32'd1);
        chk("other_ready", 32'(m ? m0_ready : m1_ready), 32'd0);
        chk("other_rdata", m ? m0_rdata : m1_rdata, 32'h0);
        if (!e.err) begin
            chk("s_valid_at_ready", 32'(s_valid), 32'd1);
            chk("s_addr", s_addr, e.r.addr);
            chk("s_wdata", s_wdata, e.r.wdata);
            chk("s_wstrb", 32'(s_wstrb), 32'(e.r.wstrb));
            chk("s_instr", 32'(s_instr), 32'(e.r.instr));
        end
        if (order_en) begin
            if (order_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL order: got master %0d expected none", m);
            end else begin
                chk("order", 32'(m), 32'(order_q.pop_front()));
            end
        end
    endtask

    task automatic mon();
        exp_t e;
        if (prev_fire) chk("idle_after_ready", 32'(s_valid), 32'd0);
        prev_fire = s_valid && s_ready;
        if (s_valid) begin
            run++;
        end else begin
            if (err) chk("busy_cycles_before_abort", 32'(run), 32'd4);
            run = 0;
        end
        if (m0_ready) begin
            if (exp_q0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL spurious_m0_ready: got 1 expected 0 at %0t", $time);
            end else begin
                e = exp_q0.pop_front();
                check_xfer(1'b0, e);
            end
        end
        if (m1_ready) begin
            if (exp_q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL spurious_m1_ready: got 1 expected 0 at %0t", $time);
            end else begin
                e = exp_q1.pop_front();
                check_xfer(1'b1, e);
            end
        end
        if (err && !m0_ready && !m1_ready) chk("err_without_ready", 32'(err), 32'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive_masters();
        @(negedge clk);
        ack0 = m0_ready;
        ack1 = m1_ready;
        mon();
    endtask

    task automatic flush();
        m0_valid = 1'b0; m1_valid = 1'b0;
        ack0 = 1'b0; ack1 = 1'b0;
        req_q0.delete(); req_q1.delete();
        exp_q0.delete(); exp_q1.delete();
        order_q.delete();
    endtask

    task automatic run_engine(input int max);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(req_q0.size() == 0 && req_q1.size() == 0 && !m0_valid && !m1_valid) && n < max);
        if (m0_valid || m1_valid || req_q0.size() != 0 || req_q1.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL engine_timeout: got pending after %0d cycles expected idle", n);
            flush();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    vec_t vt[7];

    initial begin
        int n0, n1;
        int base;
        logic [31:0] v;

        vt[0] = '{1, 0, 0, 0, 32'h10,  32'h0,   32'h0,         32'h0,         4'h0, 4'h0, 2, 0};
        vt[1] = '{1, 1, 1, 0, 32'h100, 32'h200, 32'h0,         32'h0,         4'h0, 4'h0, 1, 1};
        vt[2] = '{0, 1, 0, 0, 32'h0,   32'h3FC, 32'h0,         32'h5,         4'h0, 4'hF, 1, 1};
        vt[3] = '{1, 1, 0, 1, 32'h40,  32'h44,  32'hA5A5_5A5A, 32'h0,         4'h3, 4'h0, 0, 0};
        vt[4] = '{1, 1, 0, 0, 32'h80,  32'h84,  32'h0,         32'hFFFF_0000, 4'h0, 4'hC, 3, 0};
        vt[5] = '{1, 0, 1, 0, 32'h4,   32'h0,   32'h0,         32'h0,         4'h0, 4'h0, 1, 0};
        vt[6] = '{1, 1, 0, 0, 32'h8,   32'hC,   32'h0,         32'h0,         4'h0, 4'h0, 2, 1};

        resetn = 1'b0;
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        ack0 = 0; ack1 = 0; prev_fire = 0; run = 0; order_en = 1;

        repeat (2) @(negedge clk);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_m0_ready", 32'(m0_ready), 32'd0);
        chk("rst_m1_ready", 32'(m1_ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        resetn = 1'b1;

        // arbitration table; expected service order is the 'first' column
        foreach (vt[k]) begin
            slave_dly = vt[k].dly;
            if (vt[k].v0) req_q0.push_back(mk(vt[k].i0, vt[k].a0, vt[k].d0, vt[k].w0));
            if (vt[k].v1) req_q1.push_back(mk(vt[k].i1, vt[k].a1, vt[k].d1, vt[k].w1));
            order_q.push_back(vt[k].first);
            if (vt[k].v0 && vt[k].v1) order_q.push_back(!vt[k].first);
            run_engine(60);
        end

        // continuous requests from both masters alternate; m0 had last turn
        slave_dly = 1;
        for (int i = 0; i < 3; i++) begin
            req_q0.push_back(mk(1'b0, 32'h1000 + 32'(4 * i), 32'h0, 4'h0));
            req_q1.push_back(mk(1'b0, 32'h2000 + 32'(4 * i), 32'(i), 4'hF));
            order_q.push_back(1'b1);
            order_q.push_back(1'b0);
        end
        run_engine(80);

        // watchdog abort, then stray s_ready while idle
        slave_mode = 1;
        req_q0.push_back(mk(1'b0, 32'h500, 32'h0, 4'h0));
        order_q.push_back(1'b0);
        run_engine(40);
        slave_mode = 2;
        repeat (3) begin
            cycle();
            chk("stray_m0_ready", 32'(m0_ready), 32'd0);
            chk("stray_m1_ready", 32'(m1_ready), 32'd0);
            chk("stray_err", 32'(err), 32'd0);
        end
        slave_mode = 0;
        repeat (2) cycle();

        // reset in the middle of an m1 transfer; last turn was m0 beforehand
        slave_dly = 1;
        req_q0.push_back(mk(1'b0, 32'h600, 32'h0, 4'h0));
        order_q.push_back(1'b0);
        run_engine(40);
        slave_mode = 1;
        req_q1.push_back(mk(1'b0, 32'h3F0, 32'h77, 4'hF));
        repeat (3) cycle();
        chk("busy1_gnt", 32'(gnt), 32'd2);
        chk("busy1_s_valid", 32'(s_valid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_s_valid", 32'(s_valid), 32'd0);
        chk("async_rst_m1_ready", 32'(m1_ready), 32'd0);
        chk("async_rst_gnt", 32'(gnt), 32'd0);
        flush();
        slave_mode = 0;
        req_q0.push_back(mk(1'b0, 32'h700, 32'h0, 4'h0));
        req_q1.push_back(mk(1'b0, 32'h704, 32'h0, 4'h0));
        order_q.push_back(1'b0);
        order_q.push_back(1'b1);
        cycle();
        #1 resetn = 1'b1;
        run_engine(60);

        // two cores running the counter loop: fetch, lw, fetch, sw 0x3FC
        order_en = 0;
        base = wlog.size();
        for (int i = 0; i < 4; i++) begin
            req_q0.push_back(mk(1'b1, 32'h0000 + 32'(16 * i), 32'h0, 4'h0));
            req_q0.push_back(mk(1'b0, 32'h3FC, 32'h0, 4'h0));
            req_q0.push_back(mk(1'b1, 32'h0004 + 32'(16 * i), 32'h0, 4'h0));
            req_q0.push_back(mk(1'b0, 32'h3FC, 32'(i), 4'hF));
            req_q1.push_back(mk(1'b1, 32'h0100 + 32'(16 * i), 32'h0, 4'h0));
            req_q1.push_back(mk(1'b0, 32'h3FC, 32'h0, 4'h0));
            req_q1.push_back(mk(1'b1, 32'h0104 + 32'(16 * i), 32'h0, 4'h0));
            req_q1.push_back(mk(1'b0, 32'h3FC, 32'h0001_0000 | 32'(i), 4'hF));
        end
        run_engine(400);
        n0 = 0; n1 = 0;
        for (int k = base; k < wlog.size(); k++) begin
            v = wlog[k];
            if (v[16]) begin
                chk("store_seq_m1", v, 32'h0001_0000 | 32'(n1));
                n1++;
            end else begin
                chk("store_seq_m0", v, 32'(n0));
                n0++;
            end
        end
        chk("stores_m0", 32'(n0), 32'd4);
        chk("stores_m1", 32'(n1), 32'd4);

        chk("leftover_exp0", 32'(exp_q0.size()), 32'd0);
        chk("leftover_exp1", 32'(exp_q1.size()), 32'd0);
        chk("leftover_order", 32'(order_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
